serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_pkg.sv | 27 ++
 rtl/baud_counter.sv | 46 ++++
 rtl/sync_en_flop.sv | 23 ++
 rtl/serial_tx.sv | 134 +++++++++++++
 tb/tb_serial_tx.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver.
package serial_pkg;

  // Legacy state encodings, kept as plain constants for older users.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Frame-level state shared by transmitter and receiver.
  typedef enum logic [1:0] {
    TX_IDLE  = ST_IDLE,
    TX_START = ST_START,
    TX_DATA  = ST_DATA,
    TX_STOP  = ST_STOP
  } tx_state_t;

  // Counter width for a count of 0..n-1; never narrower than one bit.
  function automatic int min1_clog2(input int n);
    if (n > 32'sd1) begin
      return $clog2(n);
    end else begin
      return 32'sd1;
    end
  endfunction

endpackage

// File: rtl/baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags
// the terminal count so the FSM knows when a serial bit ends.
module baud_counter
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic wrap
);

  localparam int            CW   = min1_clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_r;
  logic          term_s;

  // Decode the last cycle of the current bit period.
  always_comb begin
    term_s = 1'b0;
    if (cnt_r == LAST) begin
      term_s = 1'b1;
    end else begin
      term_s = 1'b0;
    end
  end

  assign wrap = en & term_s;

  // Count while enabled; park at zero whenever the line is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (!en) begin
      cnt_r <= '0;
    end else if (term_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + ONE;
    end
  end

endmodule

// File: rtl/sync_en_flop.sv
// Enabled register with synchronous active-high clear.
module sync_en_flop #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d when enabled, clear on reset, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start bit (0), WIDTH data bits LSB-first, stop bit (1),
// each bit held for CLKS_PER_BIT clocks. The line is driven from a flop.
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             tx_out,
  output logic             busy,
  output logic             done
);

  localparam int            BW       = min1_clog2(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  tx_state_t        state_r;
  tx_state_t        state_nxt_s;
  logic [BW-1:0]    bit_r;
  logic [BW-1:0]    bit_nxt_s;
  logic             tx_r;
  logic             tx_nxt_s;
  logic [WIDTH-1:0] hold_s;
  logic             accept_s;
  logic             wrap_s;
  logic             busy_s;

  assign busy_s   = (state_r != TX_IDLE);
  assign in_ready = (state_r == TX_IDLE) && !reset;
  assign accept_s = in_valid && in_ready;
  assign busy     = busy_s;
  assign done     = (state_r == TX_STOP) && wrap_s;
  assign tx_out   = tx_r;

  // Word is captured only on acceptance, so input changes mid-frame are ignored.
  sync_en_flop #(
    .W (WIDTH)
  ) u_hold (
    .clk   (clk),
    .reset (reset),
    .en    (accept_s),
    .d     (in_data),
    .q     (hold_s)
  );

  // Bit timing runs only while a frame is in flight.
  baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .en    (busy_s),
    .wrap  (wrap_s)
  );

  // Frame sequencing and bit-index advance at each bit-period boundary.
  always_comb begin
    state_nxt_s = state_r;
    bit_nxt_s   = bit_r;
    case (state_r)
      TX_IDLE: begin
        if (accept_s) begin
          state_nxt_s = TX_START;
          bit_nxt_s   = '0;
        end else begin
          state_nxt_s = TX_IDLE;
        end
      end
      TX_START: begin
        if (wrap_s) begin
          state_nxt_s = TX_DATA;
          bit_nxt_s   = '0;
        end else begin
          state_nxt_s = TX_START;
        end
      end
      TX_DATA: begin
        if (wrap_s) begin
          if (bit_r == BIT_LAST) begin
            state_nxt_s = TX_STOP;
          end else begin
            bit_nxt_s = bit_r + BIT_ONE;
          end
        end else begin
          state_nxt_s = TX_DATA;
        end
      end
      TX_STOP: begin
        if (wrap_s) begin
          state_nxt_s = TX_IDLE;
          bit_nxt_s   = '0;
        end else begin
          state_nxt_s = TX_STOP;
        end
      end
      default: begin
        state_nxt_s = TX_IDLE;
        bit_nxt_s   = '0;
      end
    endcase
  end

  // Line level for the upcoming cycle, chosen from the upcoming state.
  always_comb begin
    tx_nxt_s = 1'b1;
    case (state_nxt_s)
      TX_IDLE:  tx_nxt_s = 1'b1;
      TX_START: tx_nxt_s = 1'b0;
      TX_DATA:  tx_nxt_s = hold_s[bit_nxt_s];
      TX_STOP:  tx_nxt_s = 1'b1;
      default:  tx_nxt_s = 1'b1;
    endcase
  end

  // State, bit index and serial line registers; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= TX_IDLE;
      bit_r   <= '0;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      bit_r   <= bit_nxt_s;
      tx_r    <= tx_nxt_s;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: stimulus pushes the expected per-cycle line
// level and done flag on each acceptance; monitors pop and compare each cycle.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, tx_out, busy, done;
  logic [7:0] in_data;
  logic       in_valid1, in_ready1, tx_out1, busy1, done1;
  logic [7:0] in_data1;

  logic [1:0] exp_q0[$];
  logic [1:0] exp_q1[$];
  logic [1:0] e0, e1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .tx_out(tx_out), .busy(busy), .done(done)
  );

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .tx_out(tx_out1), .busy(busy1), .done(done1)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // bits[k] is frame bit k in line order (k=0 start, k=9 stop).
  task automatic push_frame(input int which, input logic [9:0] bits, input int cpb);
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < cpb; c++) begin
        logic [1:0] e;
        e = {bits[k], ((k == 9) && (c == cpb - 1)) ? 1'b1 : 1'b0};
        if (which == 0) exp_q0.push_back(e);
        else            exp_q1.push_back(e);
      end
    end
  endtask

  // Monitor for the CLKS_PER_BIT=4 instance.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) begin
        if (exp_q0.size() == 0) begin
          total++; bad++;
          $display("FAIL dut0_extra_frame: busy=1 expected busy=0 at %0t", $time);
        end else begin
          e0 = exp_q0.pop_front();
          check("dut0_tx", {7'd0, tx_out}, {7'd0, e0[1]});
          check("dut0_done", {7'd0, done}, {7'd0, e0[0]});
        end
      end else begin
        if (exp_q0.size() != 0) begin
          total++; bad++;
          $display("FAIL dut0_missing_frame: busy=0 expected busy=1 at %0t", $time);
        end
        check("dut0_idle_tx", {7'd0, tx_out}, 8'd1);
        check("dut0_idle_done", {7'd0, done}, 8'd0);
      end
    end
  end

  // Monitor for the CLKS_PER_BIT=1 instance.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy1) begin
        if (exp_q1.size() == 0) begin
          total++; bad++;
          $display("FAIL dut1_extra_frame: busy=1 expected busy=0 at %0t", $time);
        end else begin
          e1 = exp_q1.pop_front();
          check("dut1_tx", {7'd0, tx_out1}, {7'd0, e1[1]});
          check("dut1_done", {7'd0, done1}, {7'd0, e1[0]});
        end
      end else begin
        if (exp_q1.size() != 0) begin
          total++; bad++;
          $display("FAIL dut1_missing_frame: busy=0 expected busy=1 at %0t", $time);
        end
        check("dut1_idle_tx", {7'd0, tx_out1}, 8'd1);
        check("dut1_idle_done", {7'd0, done1}, 8'd0);
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    in_valid1 = 1'b0; in_data1 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {7'd0, tx_out}, 8'd1);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_done", {7'd0, done}, 8'd0);
    check("rst_ready", {7'd0, in_ready}, 8'd0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", {7'd0, in_ready}, 8'd1);

    // 0xA5: 0,1,0,1,0,0,1,0,1,1
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hA5;
    @(posedge clk); #1;
    push_frame(0, 10'b11_0100_1010, 4);
    in_valid = 1'b0;
    check("a5_ready_busy", {7'd0, in_ready}, 8'd0);
    check("a5_busy", {7'd0, busy}, 8'd1);
    repeat (40) @(posedge clk);
    #1;
    check("a5_ready_c41", {7'd0, in_ready}, 8'd1);
    check("a5_busy_c41", {7'd0, busy}, 8'd0);

    // Back-to-back 0x00 then 0xFF with in_valid held high.
    in_valid = 1'b1; in_data = 8'h00;
    @(posedge clk); #1;
    push_frame(0, 10'b10_0000_0000, 4);
    in_data = 8'hFF;
    repeat (41) @(posedge clk);
    #1;
    push_frame(0, 10'b11_1111_1110, 4);
    in_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("b2b_idle_busy", {7'd0, busy}, 8'd0);

    // 0xA5 with a 0x3C offer on cycle 10 that must be ignored.
    in_valid = 1'b1; in_data = 8'hA5;
    @(posedge clk); #1;
    push_frame(0, 10'b11_0100_1010, 4);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = 8'h3C;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("ign_busy_end", {7'd0, busy}, 8'd0);

    // Reset on cycle 17 aborts the frame; no done pulse afterwards.
    in_valid = 1'b1; in_data = 8'hA5;
    @(posedge clk); #1;
    push_frame(0, 10'b11_0100_1010, 4);
    in_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q0.delete();
    check("abort_tx", {7'd0, tx_out}, 8'd1);
    check("abort_busy", {7'd0, busy}, 8'd0);
    check("abort_done", {7'd0, done}, 8'd0);
    reset = 1'b0;
    #1;
    check("abort_ready", {7'd0, in_ready}, 8'd1);
    repeat (45) @(posedge clk);
    #1;

    // in_valid during reset must not be accepted.
    reset = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rstv_tx", {7'd0, tx_out}, 8'd1);
      check("rstv_busy", {7'd0, busy}, 8'd0);
      check("rstv_ready", {7'd0, in_ready}, 8'd0);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // CLKS_PER_BIT=1, 0x81: 0,1,0,0,0,0,0,0,1,1
    in_valid1 = 1'b1; in_data1 = 8'h81;
    @(posedge clk); #1;
    push_frame(1, 10'b11_0000_0010, 1);
    in_valid1 = 1'b0;
    check("c1_busy", {7'd0, busy1}, 8'd1);
    repeat (10) @(posedge clk);
    #1;
    check("c1_ready_end", {7'd0, in_ready1}, 8'd1);
    repeat (3) @(posedge clk);
    #1;

    check("q0_drained", exp_q0.size() == 0 ? 8'd1 : 8'd0, 8'd1);
    check("q1_drained", exp_q1.size() == 0 ? 8'd1 : 8'd0, 8'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
